// File: rtl/prefix_chain_decoder.sv
// Opcode decoder with a multi-level prefix chain: PREP/PREPX build a wide
// immediate and switch to the alternate opcode table; sticky HALT and stall gating.
module prefix_chain_decoder #(
  parameter int MODES = 4,
  parameter int IMMW  = 6,
  parameter int PREPW = 16,
  localparam int MW   = $clog2(MODES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic [2:0]       opcode,
  input  logic [IMMW-1:0]  imm,
  output logic             WritePrepReg,
  output logic             ReadPrepReg,
  output logic             WriteEnabled,
  output logic             DataWrite,
  output logic             DataRead,
  output logic [2:0]       ALUOp,
  output logic             controlBranch,
  output logic             aluRegSource,
  output logic             aluConstantOrOne,
  output logic             saveAluToReg,
  output logic             prepCommand,
  output logic [MW-1:0]    mode,
  output logic [PREPW-1:0] prep_value,
  output logic             halted,
  output logic             illegal
);

  localparam logic [MW-1:0] LastMode = MW'(MODES - 1);

  logic                  fire;
  logic [MW-1:0]         modeNext;
  logic [PREPW-1:0]      prepNext;
  logic                  haltedNext;
  logic [PREPW+IMMW-1:0] prepShifted;

  assign fire        = instr_valid & ~stall & ~halted;
  // Upper bits fall off when the chain outgrows the prep register.
  assign prepShifted = {prep_value, imm};

  always_comb begin
    WritePrepReg     = 1'b0;
    ReadPrepReg      = 1'b0;
    WriteEnabled     = 1'b0;
    DataWrite        = 1'b0;
    DataRead         = 1'b0;
    ALUOp            = 3'b000;
    controlBranch    = 1'b0;
    aluRegSource     = 1'b0;
    aluConstantOrOne = 1'b0;
    saveAluToReg     = 1'b0;
    prepCommand      = 1'b0;
    illegal          = 1'b0;
    modeNext         = mode;
    prepNext         = prep_value;
    haltedNext       = halted;

    if (fire) begin
      if (mode == '0) begin
        case (opcode)
          3'b000: begin
            WritePrepReg = 1'b1;
            WriteEnabled = 1'b1;
            prepCommand  = 1'b1;
            modeNext     = MW'(1);
            prepNext     = PREPW'(imm);
          end
          3'b001: begin
            WriteEnabled     = 1'b1;
            aluConstantOrOne = 1'b1;
            saveAluToReg     = 1'b1;
            ALUOp            = imm[0] ? 3'b000 : 3'b001;
          end
          3'b010: begin
            ALUOp        = 3'b010;
            aluRegSource = 1'b1;
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
          end
          3'b011: begin
            ALUOp        = 3'b011;
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
          end
          3'b100: begin
            ALUOp        = 3'b100;
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
          end
          3'b101: begin
            ALUOp        = 3'b101;
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
          end
          3'b110:  illegal    = 1'b1;
          default: haltedNext = 1'b1;
        endcase
      end else begin
        ReadPrepReg = 1'b1;
        case (opcode)
          3'b000: begin
            ALUOp        = 3'b110;
            aluRegSource = 1'b1;
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
            modeNext     = '0;
          end
          3'b001: begin
            ALUOp         = 3'b111;
            controlBranch = 1'b1;
            aluRegSource  = 1'b1;
            modeNext      = '0;
          end
          3'b010: begin
            DataRead     = 1'b1;
            WriteEnabled = 1'b1;
            modeNext     = '0;
          end
          3'b011: begin
            DataWrite = 1'b1;
            modeNext  = '0;
          end
          3'b100: begin
            WriteEnabled = 1'b1;
            modeNext     = '0;
          end
          3'b101: begin
            ALUOp        = 3'b100;
            WritePrepReg = 1'b1;
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
          end
          3'b110: begin
            ALUOp        = 3'b010;
            aluRegSource = 1'b1;
            WritePrepReg = 1'b1;
            WriteEnabled = 1'b1;
            saveAluToReg = 1'b1;
          end
          default: begin
            if (mode != LastMode) begin
              WritePrepReg = 1'b1;
              WriteEnabled = 1'b1;
              prepCommand  = 1'b1;
              modeNext     = mode + MW'(1);
              prepNext     = prepShifted[PREPW-1:0];
            end else begin
              // Chain too deep: abandon it but keep the accumulated value.
              ReadPrepReg = 1'b0;
              illegal     = 1'b1;
              modeNext    = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode       <= '0;
      prep_value <= '0;
      halted     <= 1'b0;
    end else begin
      mode       <= modeNext;
      prep_value <= prepNext;
      halted     <= haltedNext;
    end
  end

endmodule

// File: tb/tb_prefix_chain_decoder.sv
// Directed bench for prefix_chain_decoder: expected controls and state are queued
// when each instruction is driven and checked as the DUT responds.
module tb_prefix_chain_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        stall;
  logic [2:0]  opcode;
  logic [5:0]  imm;
  logic        WritePrepReg, ReadPrepReg, WriteEnabled, DataWrite, DataRead;
  logic [2:0]  ALUOp;
  logic        controlBranch, aluRegSource, aluConstantOrOne, saveAluToReg, prepCommand;
  logic [1:0]  mode;
  logic [15:0] prep_value;
  logic        halted;
  logic        illegal;
  logic [13:0] obsCtl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [13:0] ctl;
    logic [1:0]  mode;
    logic [15:0] prep;
    logic        halt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  prefix_chain_decoder #(.MODES(4), .IMMW(6), .PREPW(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .stall(stall),
    .opcode(opcode), .imm(imm),
    .WritePrepReg(WritePrepReg), .ReadPrepReg(ReadPrepReg), .WriteEnabled(WriteEnabled),
    .DataWrite(DataWrite), .DataRead(DataRead), .ALUOp(ALUOp),
    .controlBranch(controlBranch), .aluRegSource(aluRegSource),
    .aluConstantOrOne(aluConstantOrOne), .saveAluToReg(saveAluToReg),
    .prepCommand(prepCommand), .mode(mode), .prep_value(prep_value),
    .halted(halted), .illegal(illegal)
  );

  assign obsCtl = {WritePrepReg, ReadPrepReg, WriteEnabled, DataWrite, DataRead, ALUOp,
                   controlBranch, aluRegSource, aluConstantOrOne, saveAluToReg,
                   prepCommand, illegal};

  function automatic logic [13:0] ctl(input logic wpr, rpr, we, dw, dr,
                                      input logic [2:0] alu,
                                      input logic cb, ars, aco, sav, pc, ill);
    return {wpr, rpr, we, dw, dr, alu, cb, ars, aco, sav, pc, ill};
  endfunction

  localparam logic [13:0] C_NONE  = 14'd0;
  localparam logic [13:0] C_PREP  = ctl(1,0,1,0,0,3'b000,0,0,0,0,1,0);
  localparam logic [13:0] C_INC1  = ctl(0,0,1,0,0,3'b000,0,0,1,1,0,0);
  localparam logic [13:0] C_INC0  = ctl(0,0,1,0,0,3'b001,0,0,1,1,0,0);
  localparam logic [13:0] C_XOR   = ctl(0,0,1,0,0,3'b010,0,1,0,1,0,0);
  localparam logic [13:0] C_XORR  = ctl(0,0,1,0,0,3'b011,0,0,0,1,0,0);
  localparam logic [13:0] C_SLL   = ctl(0,0,1,0,0,3'b100,0,0,0,1,0,0);
  localparam logic [13:0] C_SRL   = ctl(0,0,1,0,0,3'b101,0,0,0,1,0,0);
  localparam logic [13:0] C_ILL   = ctl(0,0,0,0,0,3'b000,0,0,0,0,0,1);
  localparam logic [13:0] C_ANDI  = ctl(0,1,1,0,0,3'b110,0,1,0,1,0,0);
  localparam logic [13:0] C_BEQ   = ctl(0,1,0,0,0,3'b111,1,1,0,0,0,0);
  localparam logic [13:0] C_LW    = ctl(0,1,1,0,1,3'b000,0,0,0,0,0,0);
  localparam logic [13:0] C_SW    = ctl(0,1,0,1,0,3'b000,0,0,0,0,0,0);
  localparam logic [13:0] C_SAVE  = ctl(0,1,1,0,0,3'b000,0,0,0,0,0,0);
  localparam logic [13:0] C_PSFT  = ctl(1,1,1,0,0,3'b100,0,0,0,1,0,0);
  localparam logic [13:0] C_PXOR  = ctl(1,1,1,0,0,3'b010,0,1,0,1,0,0);
  localparam logic [13:0] C_PREPX = ctl(1,1,1,0,0,3'b000,0,0,0,0,1,0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [1:0] em,
                            input logic [15:0] ep, input logic eh);
    chk({tag, ".mode"}, 32'(mode), 32'(em));
    chk({tag, ".prep"}, 32'(prep_value), 32'(ep));
    chk({tag, ".halted"}, 32'(halted), 32'(eh));
  endtask

  // Called just after a rising edge; leaves time just after the next rising edge.
  task automatic issue(input string tag, input logic v, input logic s,
                       input logic [2:0] op, input logic [5:0] im,
                       input logic [13:0] ec, input logic [1:0] em,
                       input logic [15:0] ep, input logic eh);
    exp_t e;
    instr_valid = v;
    stall       = s;
    opcode      = op;
    imm         = im;
    e.tag = tag; e.ctl = ec; e.mode = em; e.prep = ep; e.halt = eh;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".ctl"}, 32'(obsCtl), 32'(e.ctl));
    @(posedge clk);
    #1;
    checkState(e.tag, e.mode, e.prep, e.halt);
  endtask

  task automatic doReset(input string tag);
    instr_valid = 1'b0;
    stall       = 1'b0;
    reset       = 1'b0;
    #2;
    checkState(tag, 2'd0, 16'h0000, 1'b0);
    chk({tag, ".ctl"}, 32'(obsCtl), 32'(C_NONE));
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; stall = 1'b0; opcode = 3'b000; imm = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    checkState("por", 2'd0, 16'h0000, 1'b0);
    chk("por.ctl", 32'(obsCtl), 32'(C_NONE));
    reset = 1'b1;

    issue("prep5",   1, 0, 3'b000, 6'd5,  C_PREP,  2'd1, 16'h0005, 0);
    issue("lw",      1, 0, 3'b010, 6'd0,  C_LW,    2'd0, 16'h0005, 0);

    issue("chain1",  1, 0, 3'b000, 6'd1,  C_PREP,  2'd1, 16'h0001, 0);
    issue("chain2",  1, 0, 3'b111, 6'd2,  C_PREPX, 2'd2, 16'h0042, 0);
    issue("chain3",  1, 0, 3'b111, 6'd3,  C_PREPX, 2'd3, 16'h1083, 0);
    issue("chainOv", 1, 0, 3'b111, 6'd4,  C_ILL,   2'd0, 16'h1083, 0);

    issue("inc1",    1, 0, 3'b001, 6'd1,  C_INC1,  2'd0, 16'h1083, 0);
    issue("inc0",    1, 0, 3'b001, 6'd0,  C_INC0,  2'd0, 16'h1083, 0);
    issue("ill110",  1, 0, 3'b110, 6'd0,  C_ILL,   2'd0, 16'h1083, 0);
    issue("xor",     1, 0, 3'b010, 6'h15, C_XOR,   2'd0, 16'h1083, 0);
    issue("xorr",    1, 0, 3'b011, 6'd0,  C_XORR,  2'd0, 16'h1083, 0);
    issue("sll",     1, 0, 3'b100, 6'd0,  C_SLL,   2'd0, 16'h1083, 0);
    issue("srl",     1, 0, 3'b101, 6'd0,  C_SRL,   2'd0, 16'h1083, 0);
    issue("novalid", 0, 0, 3'b010, 6'd0,  C_NONE,  2'd0, 16'h1083, 0);

    issue("prep3",   1, 0, 3'b000, 6'd3,  C_PREP,  2'd1, 16'h0003, 0);
    issue("stall1",  1, 1, 3'b101, 6'd0,  C_NONE,  2'd1, 16'h0003, 0);
    issue("stall2",  1, 1, 3'b101, 6'd0,  C_NONE,  2'd1, 16'h0003, 0);
    issue("psft",    1, 0, 3'b101, 6'd0,  C_PSFT,  2'd1, 16'h0003, 0);
    issue("pxor",    1, 0, 3'b110, 6'd0,  C_PXOR,  2'd1, 16'h0003, 0);
    issue("beq",     1, 0, 3'b001, 6'd0,  C_BEQ,   2'd0, 16'h0003, 0);

    issue("prep3f",  1, 0, 3'b000, 6'h3F, C_PREP,  2'd1, 16'h003F, 0);
    issue("andi",    1, 0, 3'b000, 6'd0,  C_ANDI,  2'd0, 16'h003F, 0);
    issue("prep2",   1, 0, 3'b000, 6'd2,  C_PREP,  2'd1, 16'h0002, 0);
    issue("sw",      1, 0, 3'b011, 6'd0,  C_SW,    2'd0, 16'h0002, 0);
    issue("prep4",   1, 0, 3'b000, 6'd4,  C_PREP,  2'd1, 16'h0004, 0);
    issue("save",    1, 0, 3'b100, 6'd0,  C_SAVE,  2'd0, 16'h0004, 0);

    issue("trunc1",  1, 0, 3'b000, 6'h3F, C_PREP,  2'd1, 16'h003F, 0);
    issue("trunc2",  1, 0, 3'b111, 6'h3F, C_PREPX, 2'd2, 16'h0FFF, 0);
    issue("trunc3",  1, 0, 3'b111, 6'h3F, C_PREPX, 2'd3, 16'hFFFF, 0);
    issue("lwDeep",  1, 0, 3'b010, 6'd0,  C_LW,    2'd0, 16'hFFFF, 0);

    issue("prep7",   1, 0, 3'b000, 6'd7,  C_PREP,  2'd1, 16'h0007, 0);
    doReset("midRst");
    issue("postRst", 1, 0, 3'b000, 6'd9,  C_PREP,  2'd1, 16'h0009, 0);
    issue("save2",   1, 0, 3'b100, 6'd0,  C_SAVE,  2'd0, 16'h0009, 0);

    issue("halt",    1, 0, 3'b111, 6'd0,  C_NONE,  2'd0, 16'h0009, 1);
    issue("hXor",    1, 0, 3'b010, 6'd0,  C_NONE,  2'd0, 16'h0009, 1);
    issue("hPrep",   1, 0, 3'b000, 6'd1,  C_NONE,  2'd0, 16'h0009, 1);
    doReset("haltRst");
    issue("revive",  1, 0, 3'b010, 6'd0,  C_XOR,   2'd0, 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefix_chain_decoder.md
# prefix_chain_decoder

Parametrised successor to the single-level prep control decoder. It decodes 3-bit opcodes into the datapath control bundle and tracks a multi-level prefix state. A chain of prefix instructions (PREP, then PREPX) accumulates a wide immediate in an internal prep register and selects the alternate opcode table. It also provides sticky HALT, an illegal-opcode flag and pipeline stall gating. It sits between instruction fetch and the regfile/ALU/data-memory control inputs.

## Interface
- MODES, 4: number of prefix levels including base mode 0; must be >= 2; MW = $clog2(MODES)
- IMMW, 6: immediate field width per instruction
- PREPW, 16: accumulated prep value width; must be >= IMMW
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; one clock; clears all state
- instr_valid  in  1  opcode/imm valid this cycle
- stall  in  1  hold; instruction not consumed
- opcode  in  3  instruction opcode
- imm  in  IMMW  immediate field; imm[0] selects INC/DEC
- WritePrepReg, ReadPrepReg, WriteEnabled, DataWrite, DataRead  out  1 each  regfile/memory controls
- ALUOp  out  3  ALU operation
- controlBranch, aluRegSource, aluConstantOrOne, saveAluToReg, prepCommand  out  1 each  datapath muxes
- mode  out  MW  current prefix level
- prep_value  out  PREPW  accumulated prefix immediate
- halted  out  1  sticky halt
- illegal  out  1  one-cycle illegal-opcode flag

## Operation
- fire = instr_valid & ~stall & ~halted. If fire is 0, every control output and illegal is 0, and state holds.
- Control outputs are combinational from mode, opcode and imm. Any field not listed below is 0.
- Mode 0 table:
  - 000 PREP: WritePrepReg, WriteEnabled, prepCommand. Next state: mode=1, prep_value={0,imm}.
  - 001 INC/DEC: WriteEnabled, aluConstantOrOne, saveAluToReg. ALUOp=000 if imm[0], else 001.
  - 010 XOR: ALUOp=010, aluRegSource, WriteEnabled, saveAluToReg.
  - 011 XORR: ALUOp=011, WriteEnabled, saveAluToReg.
  - 100 SLL: ALUOp=100, WriteEnabled, saveAluToReg.
  - 101 SRL: ALUOp=101, WriteEnabled, saveAluToReg.
  - 110: illegal=1, no writes, mode stays 0.
  - 111 HALT: no writes. halted=1 from next edge.
- Mode >= 1 table; ReadPrepReg=1 in all rows except illegal:
  - 000 ANDI: ALUOp=110, aluRegSource, WriteEnabled, saveAluToReg. Next mode 0.
  - 001 BEQ: ALUOp=111, controlBranch, aluRegSource. Next mode 0.
  - 010 LW: DataRead, WriteEnabled. Next mode 0.
  - 011 SW: DataWrite. Next mode 0.
  - 100 SAVE: WriteEnabled. Next mode 0.
  - 101 PSFT: ALUOp=100, WritePrepReg, WriteEnabled, saveAluToReg. Mode unchanged.
  - 110 PXOR: ALUOp=010, aluRegSource, WritePrepReg, WriteEnabled, saveAluToReg. Mode unchanged.
  - 111 PREPX, when mode < MODES-1: WritePrepReg, WriteEnabled, prepCommand. Next state: mode+1, prep_value = (prep_value << IMMW) | imm, truncated to PREPW (high bits drop).
  - 111 PREPX, when mode == MODES-1: illegal=1, ReadPrepReg=0, no writes. Next mode 0; prep_value unchanged.
- Returning to mode 0 does not clear prep_value. Only PREP overwrites it.
- halted clears only on reset.

## Timing
- Reset (reset=0, asynchronous) sets mode=0, prep_value=0, halted=0. With fire=0, all controls and illegal are 0.
- Decode latency is 0: controls are valid in the same cycle as opcode when fire=1.
- mode, prep_value and halted update on the rising clk edge where fire=1. The new mode applies to the next instruction.
- A stalled instruction produces no controls and no state change. The same instruction re-presented after stall drops decodes identically.
- reset asserted mid-chain abandons the prefix. The next instruction decodes in mode 0.
- HALT: outputs are 0 in the HALT cycle. halted=1 after the edge, and all subsequent instructions are ignored.
- Back-to-back prefixes are allowed every cycle. There are no bubbles.

## Test plan
- Reset, then PREP imm=5 -> WritePrepReg=1, prepCommand=1. After the edge: mode=1, prep_value=5. Then LW -> DataRead=1, ReadPrepReg=1, ALUOp=000. After the edge: mode=0.
- MODES=4, IMMW=6: PREP 1, PREPX 2, PREPX 3 -> prep_value=0x1083, mode=3. Next PREPX -> illegal=1, mode=0, prep_value=0x1083.
- Mode 0: INC imm=1 -> ALUOp=000. INC imm=0 -> ALUOp=001. Both assert aluConstantOrOne=1. Opcode 110 -> illegal=1, WriteEnabled=0.
- PREP 3, then PSFT with stall=1 for 2 cycles -> all controls 0, mode stays 1. Stall drops -> WritePrepReg=1, ALUOp=100, mode remains 1. Then BEQ -> controlBranch=1, ALUOp=111, mode=0.
- PREP 7, then assert reset for 1 cycle mid-chain -> mode=0, prep_value=0. Next opcode 000 decodes as PREP, not ANDI.
- HALT in mode 0 -> halted=1 next cycle. Subsequent XOR with instr_valid=1 -> WriteEnabled=0. Reset -> halted=0.
